hazard_ctrl: RTL and testbench

Central pipeline sequencing unit for the 5-stage MIPS R2000 core (IF/ID/EX/MEM/WB).
- Detects load-use hazards and inserts bubbles.
- Gates taken branches and squashes the wrong-path fetch.
- Sequences the multi-cycle mult/div unit and stalls HI/LO consumers while it is busy.
- Drains the pipeline on exceptions.
It drives the hold_pc, hold_if and flush_ex controls consumed by the IF and EX stages.

---
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if : pipeline <-> hazard controller signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        br;
    logic        id_muldiv;
    logic        id_hilo_read;
    logic        except;

    logic        hold_pc;
    logic        hold_if;
    logic        flush_if;
    logic        flush_ex;
    logic        br_take;
    logic        muldiv_start;
    logic        muldiv_busy;
    logic        exc_redirect;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, br,
               id_muldiv, id_hilo_read, except,
        input  hold_pc, hold_if, flush_if, flush_ex, br_take,
               muldiv_start, muldiv_busy, exc_redirect, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, br,
               id_muldiv, id_hilo_read, except,
        output hold_pc, hold_if, flush_if, flush_ex, br_take,
               muldiv_start, muldiv_busy, exc_redirect, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : 5-stage MIPS pipeline sequencer (load-use, branch, mult/div,
//               exception drain)
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MULDIV_CYCLES    = 32,
    parameter int DELAY_SLOT       = 1,
    parameter int EXC_DRAIN_CYCLES = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_BUSY   = 2'd1,
        EXC_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] c_MD_LOAD      = 8'(MULDIV_CYCLES - 1);
    localparam logic [3:0] c_EX_LOAD      = 4'(EXC_DRAIN_CYCLES - 1);
    localparam logic       c_SQUASH_ON_BR = (DELAY_SLOT == 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_md_cnt;
    logic [7:0]  w_md_cnt_nxt;
    logic [3:0]  r_ex_cnt;
    logic [3:0]  w_ex_cnt_nxt;
    logic [15:0] r_stall_cnt;

    logic w_lu;
    logic w_hl;
    logic w_stall;
    logic w_hold_pc;
    logic w_hold_if;
    logic w_flush_if;
    logic w_flush_ex;
    logic w_br_take;
    logic w_muldiv_start;
    logic w_exc_redirect;

    always_comb begin
        w_lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
               ((bus.ex_rt == bus.id_rs) ||
                (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        w_hl = (r_state == MD_BUSY) && (bus.id_hilo_read || bus.id_muldiv);
        w_stall = (w_lu || w_hl) && !bus.except && (r_state != EXC_DRAIN);
    end

    // Priority: exception > drain > stall > normal flow.
    always_comb begin
        w_hold_pc      = 1'b0;
        w_hold_if      = 1'b0;
        w_flush_if     = 1'b0;
        w_flush_ex     = 1'b0;
        w_br_take      = 1'b0;
        w_muldiv_start = 1'b0;
        w_exc_redirect = 1'b0;
        if (bus.except) begin
            w_flush_if     = 1'b1;
            w_flush_ex     = 1'b1;
            w_exc_redirect = 1'b1;
        end else if (r_state == EXC_DRAIN) begin
            w_flush_if = 1'b1;
            w_flush_ex = 1'b1;
        end else if (w_stall) begin
            w_hold_pc  = 1'b1;
            w_hold_if  = 1'b1;
            w_flush_ex = 1'b1;
        end else begin
            w_br_take      = bus.br;
            w_flush_if     = bus.br && c_SQUASH_ON_BR;
            w_muldiv_start = bus.id_muldiv && (r_state == RUN);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_ex_cnt_nxt = r_ex_cnt;
        if (bus.except) begin
            w_state_nxt  = EXC_DRAIN;
            w_ex_cnt_nxt = c_EX_LOAD;
            w_md_cnt_nxt = 8'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.id_muldiv && !w_stall) begin
                        w_state_nxt  = MD_BUSY;
                        w_md_cnt_nxt = c_MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_md_cnt == 8'd0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_md_cnt_nxt = r_md_cnt - 8'd1;
                    end
                end
                EXC_DRAIN: begin
                    if (r_ex_cnt == 4'd0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_ex_cnt_nxt = r_ex_cnt - 4'd1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_md_cnt    <= 8'd0;
            r_ex_cnt    <= 4'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            r_ex_cnt <= w_ex_cnt_nxt;
            if (w_hold_pc && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Outputs are forced low while reset is held so they clear without a clock.
    assign bus.hold_pc      = w_hold_pc      && !reset;
    assign bus.hold_if      = w_hold_if      && !reset;
    assign bus.flush_if     = w_flush_if     && !reset;
    assign bus.flush_ex     = w_flush_ex     && !reset;
    assign bus.br_take      = w_br_take      && !reset;
    assign bus.muldiv_start = w_muldiv_start && !reset;
    assign bus.muldiv_busy  = (r_state == MD_BUSY) && !reset;
    assign bus.exc_redirect = w_exc_redirect && !reset;
    assign bus.stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, br, id_muldiv, id_hilo_read, except;

    int n_tests;
    int n_fail;

    hazard_ctrl_if if_a ();
    hazard_ctrl_if if_b ();

    assign if_a.id_rs = id_rs;             assign if_b.id_rs = id_rs;
    assign if_a.id_rt = id_rt;             assign if_b.id_rt = id_rt;
    assign if_a.ex_rt = ex_rt;             assign if_b.ex_rt = ex_rt;
    assign if_a.id_uses_rt = id_uses_rt;   assign if_b.id_uses_rt = id_uses_rt;
    assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
    assign if_a.br = br;                   assign if_b.br = br;
    assign if_a.id_muldiv = id_muldiv;     assign if_b.id_muldiv = id_muldiv;
    assign if_a.id_hilo_read = id_hilo_read; assign if_b.id_hilo_read = id_hilo_read;
    assign if_a.except = except;           assign if_b.except = except;

    // A: 4-cycle mult/div, delay slot on.  B: 32-cycle mult/div, delay slot off.
    hazard_ctrl #(.MULDIV_CYCLES(4), .DELAY_SLOT(1), .EXC_DRAIN_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );
    hazard_ctrl #(.MULDIV_CYCLES(32), .DELAY_SLOT(0), .EXC_DRAIN_CYCLES(2)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );

    // {hold_pc, hold_if, flush_if, flush_ex, br_take, muldiv_start, muldiv_busy, exc_redirect}
    logic [7:0] a_o, b_o;
    assign a_o = {if_a.hold_pc, if_a.hold_if, if_a.flush_if, if_a.flush_ex,
                  if_a.br_take, if_a.muldiv_start, if_a.muldiv_busy, if_a.exc_redirect};
    assign b_o = {if_b.hold_pc, if_b.hold_if, if_b.flush_if, if_b.flush_ex,
                  if_b.br_take, if_b.muldiv_start, if_b.muldiv_busy, if_b.exc_redirect};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; br = 1'b0;
        id_muldiv = 1'b0; id_hilo_read = 1'b0; except = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (a_o !== 8'h00 || b_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got a=%b b=%b expected 00000000", a_o, b_o);
        end
        n_tests++;
        if (if_a.stall_cnt !== 16'd0 || if_b.stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_stall_cnt: got a=%0d b=%0d expected 0", if_a.stall_cnt, if_b.stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        n_tests++;
        if (a_o !== 8'b1101_0000) begin
            n_fail++; $display("FAIL lu_stall: got %b expected 11010000", a_o);
        end
        tick();
        ex_mem_read = 1'b0;
        #1;
        n_tests++;
        if (a_o !== 8'h00 || if_a.stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lu_release: got %b cnt=%0d expected 00000000 cnt=1", a_o, if_a.stall_cnt);
        end
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        n_tests++;
        if (a_o !== 8'h00) begin
            n_fail++; $display("FAIL lu_r0: got %b expected 00000000", a_o);
        end
        tick();
        n_tests++;
        if (if_a.stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lu_r0_cnt: got %0d expected 1", if_a.stall_cnt);
        end
    endtask

    task automatic test_rt_only();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        n_tests++;
        if (a_o !== 8'h00) begin
            n_fail++; $display("FAIL rt_unused: got %b expected 00000000", a_o);
        end
        id_uses_rt = 1'b1;
        #1;
        n_tests++;
        if (a_o !== 8'b1101_0000) begin
            n_fail++; $display("FAIL rt_used: got %b expected 11010000", a_o);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (a_o !== 8'h00 || if_a.stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL rt_release: got %b cnt=%0d expected 00000000 cnt=1", a_o, if_a.stall_cnt);
        end
    endtask

    task automatic test_muldiv();
        do_reset();
        id_muldiv = 1'b1;
        #1;
        n_tests++;
        if (a_o !== 8'b0000_0100 || b_o !== 8'b0000_0100) begin
            n_fail++; $display("FAIL md_start: got a=%b b=%b expected 00000100", a_o, b_o);
        end
        tick();
        id_muldiv = 1'b0; id_hilo_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (a_o !== 8'b1101_0010) begin
                n_fail++; $display("FAIL md_busy_stall[%0d]: got %b expected 11010010", i, a_o);
            end
            tick();
        end
        #1;
        n_tests++;
        if (a_o !== 8'h00 || if_a.stall_cnt !== 16'd4) begin
            n_fail++; $display("FAIL md_release: got %b cnt=%0d expected 00000000 cnt=4", a_o, if_a.stall_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; br = 1'b1;
        #1;
        n_tests++;
        if (a_o !== 8'b1101_0000 || b_o !== 8'b1101_0000) begin
            n_fail++; $display("FAIL br_in_stall: got a=%b b=%b expected 11010000", a_o, b_o);
        end
        tick();
        ex_mem_read = 1'b0;
        #1;
        n_tests++;
        if (a_o !== 8'b0000_1000) begin
            n_fail++; $display("FAIL br_take_ds1: got %b expected 00001000", a_o);
        end
        n_tests++;
        if (b_o !== 8'b0010_1000) begin
            n_fail++; $display("FAIL br_take_ds0: got %b expected 00101000", b_o);
        end
    endtask

    task automatic test_exception();
        do_reset();
        id_muldiv = 1'b1;
        tick();
        idle();
        #1;
        n_tests++;
        if (b_o !== 8'b0000_0010) begin
            n_fail++; $display("FAIL exc_md_busy: got %b expected 00000010", b_o);
        end
        tick();
        except = 1'b1;
        #1;
        n_tests++;
        if (b_o !== 8'b0011_0011) begin
            n_fail++; $display("FAIL exc_entry: got %b expected 00110011", b_o);
        end
        tick();
        except = 1'b0; br = 1'b1;
        #1;
        n_tests++;
        if (b_o !== 8'b0011_0000) begin
            n_fail++; $display("FAIL exc_drain1: got %b expected 00110000", b_o);
        end
        tick();
        br = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1;
        n_tests++;
        if (b_o !== 8'b0011_0000) begin
            n_fail++; $display("FAIL exc_drain2: got %b expected 00110000", b_o);
        end
        tick();
        idle();
        id_muldiv = 1'b1;
        #1;
        n_tests++;
        if (b_o !== 8'b0000_0100 || if_b.stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL exc_back_to_run: got %b cnt=%0d expected 00000100 cnt=0", b_o, if_b.stall_cnt);
        end
        tick();
        idle();
    endtask

    task automatic test_exc_retrigger();
        do_reset();
        except = 1'b1;
        #1;
        tick();
        #1;
        n_tests++;
        if (a_o !== 8'b0011_0001) begin
            n_fail++; $display("FAIL exc_retrigger: got %b expected 00110001", a_o);
        end
        tick();
        except = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (a_o !== 8'b0011_0000) begin
                n_fail++; $display("FAIL exc_reload_drain[%0d]: got %b expected 00110000", i, a_o);
            end
            tick();
        end
        id_muldiv = 1'b1;
        #1;
        n_tests++;
        if (a_o !== 8'b0000_0100) begin
            n_fail++; $display("FAIL exc_reload_exit: got %b expected 00000100", a_o);
        end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        id_muldiv = 1'b1;
        tick();
        id_muldiv = 1'b0; id_hilo_read = 1'b1;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (b_o !== 8'h00 || a_o !== 8'h00 || if_b.stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL async_rst_md: got a=%b b=%b cnt=%0d expected 0", a_o, b_o, if_b.stall_cnt);
        end
        idle();
        #2;
        reset = 1'b0;
        tick();
        id_muldiv = 1'b1;
        #1;
        n_tests++;
        if (b_o !== 8'b0000_0100) begin
            n_fail++; $display("FAIL async_rst_md_run: got %b expected 00000100", b_o);
        end
        idle();
        except = 1'b1;
        tick();
        except = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (a_o !== 8'h00 || b_o !== 8'h00) begin
            n_fail++; $display("FAIL async_rst_drain: got a=%b b=%b expected 00000000", a_o, b_o);
        end
        #2;
        reset = 1'b0;
        tick();
        #1;
        n_tests++;
        if (a_o !== 8'h00 || b_o !== 8'h00) begin
            n_fail++; $display("FAIL async_rst_drain_run: got a=%b b=%b expected 00000000", a_o, b_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
        repeat (65534) tick();
        n_tests++;
        if (if_a.stall_cnt !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_pre: got %h expected fffe", if_a.stall_cnt);
        end
        repeat (6) tick();
        n_tests++;
        if (if_a.stall_cnt !== 16'hFFFF || if_a.hold_pc !== 1'b1) begin
            n_fail++; $display("FAIL sat_hold: got %h hold_pc=%b expected ffff hold_pc=1", if_a.stall_cnt, if_a.hold_pc);
        end
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_rt_only();
        test_muldiv();
        test_branch();
        test_exception();
        test_exc_retrigger();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
